interval_timer: RTL and testbench
=================================

// Module: interval_timer
// PURPOSE
//   Reader side of the time-parameter store. The controller FSM pulses start_timer with the
//   interval it wants: 00 base, 01 extended, 10 yellow, 11 reserved.
//   This block drives that code onto the store's interval input and captures the returned
//   4-bit value, then counts it down in whole seconds. It pulses expired so the controller
//   FSM can advance the lights.
// PARAMETERS
//   TICK_DIV  100_000_000  clk cycles per one-second tick (sims use 4)
//   TIME_W    4            width of value / remaining count
// PORTS
//   clk           in   1       system clock, rising edge
//   rst_n         in   1       asynchronous, active-low reset
//   start_timer   in   1       1-cycle request to (re)start timing
//   req_interval  in   2       interval code sampled with start_timer
//   value         in   TIME_W  seconds returned by the parameter store (registered there)
//   interval      out  2       interval select driven to the parameter store
//   busy          out  1       high from the start edge until expired
//   expired       out  1       1-cycle pulse when the count reaches 0
//   remaining     out  TIME_W  seconds left (0 when idle)
//   pause         in   1       only when TIMER_PAUSE_EN is defined
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, interval=2'b00, busy=0, expired=0, remaining=0,
//     prescaler=0. All are registered outputs.
//   Store read latency: value is valid 1 edge after interval changes.
//   FSM states: IDLE -> SEL -> WAIT -> LOAD -> COUNT -> IDLE.
//   - Edge S (start_timer=1, any state): interval<=req_interval, busy<=1, expired<=0,
//     state<=SEL.
//   - SEL -> WAIT (store registers value). WAIT -> LOAD. Edge L (state LOAD):
//     remaining<=value, prescaler<=0, state<=COUNT.
//     L = S+3; no other path delays reaching LOAD.
//   - COUNT: prescaler increments each cycle. tick=(prescaler==TICK_DIV-1); on tick the
//     prescaler wraps to 0.
//     On tick with remaining>1: remaining<=remaining-1.
//     On tick with remaining==1: remaining<=0, expired<=1, busy<=0, state<=IDLE.
//   - Expired timing: value N>=1 -> expired is high exactly in the cycle after edge
//     L+N*TICK_DIV.
//   - value==0 at LOAD: expired<=1, busy<=0 on edge L+1 and state<=IDLE; no tick is waited.
//   - Code 11 (reserved): timed like any other code using whatever value is returned.
//   Boundary cases:
//   - start_timer during SEL/WAIT/LOAD/COUNT: aborts the current run and restarts at
//     edge S. No expired is emitted for the aborted run.
//   - start_timer in the same cycle as the final tick: the restart wins, no expired.
//   - A store reprogram (its Prog_Sync) during COUNT: no effect on remaining. The new
//     value applies from the next start.
//   - interval holds its last code after expiry, so the store output stays stable.
//   - rst_n asserted mid-run: immediate return to reset values. No expired.
//   Arithmetic: remaining is unsigned TIME_W bits and never decrements below 0.
//     Prescaler width is $clog2(TICK_DIV), minimum 1.
// CONFIGURATION
//   Macro TIMER_PAUSE_EN:
//   - Defined: pause port exists. While pause=1 in COUNT, prescaler and remaining hold
//     and tick is suppressed. Expiry is delayed by the number of paused cycles.
//     pause is ignored in other states; start_timer still restarts while paused.
//   - Undefined: no pause port, and the count is never held.
// STRUCTURE
//   Shared package traffic_pkg:
//   - localparams INT_BASE=2'b00, INT_EXT=2'b01, INT_YEL=2'b10, INT_RSVD=2'b11.
//   - FSM state encoding IDLE/SEL/WAIT/LOAD/COUNT. TIME_W default.
//   Sub-module second_tick: prescaler with clr, en (pause) and tick output, parameterised
//   by TICK_DIV. The top level holds the FSM and the remaining register.
// TESTING (TICK_DIV=4; bench models the store with a 1-cycle registered value)
//   1. Reset: rst_n=0 -> interval=00, busy=0, expired=0, remaining=0. Release cleanly.
//   2. Store returns 6 for interval 00; pulse start (req=00) -> interval=00 after S,
//      remaining=6 after L=S+3. Decrements every 4 cycles. expired high for 1 cycle after
//      L+24, busy low.
//   3. Store returns 0 (req=10) -> no tick waited. expired 1 cycle after L+1;
//      remaining stays 0.
//   4. During a 3-second run (req=01), re-pulse start with req=10 (value 2) at remaining=2
//      -> no expired for the first run. interval=10; expires 8 cycles after the new L.
//   5. Reprogram the store (value 15) mid-count -> remaining is unaffected.
//      Drop rst_n mid-count -> outputs reset immediately.
//   6. TIMER_PAUSE_EN: pause 5 cycles during a 2-second run -> expired 5 cycles later than
//      L+8. Build without the macro compiles with no pause port.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared constants, interval codes and timer FSM encoding
//
// Purpose: common definitions for the traffic controller slice. Imported by
//   interval_timer, second_tick and the bench.
// Contents:
//   INT_BASE/INT_EXT/INT_YEL/INT_RSVD  interval select codes driven to the store
//   TIME_W_DEFAULT                     default width of seconds values
//   timer_state_t                      interval_timer FSM states
//   prescale_w()                       prescaler width for a given divider
package traffic_pkg;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;
  localparam logic [1:0] INT_RSVD = 2'b11;

  localparam int TIME_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_COUNT = 3'd4
  } timer_state_t;

  // A divider of 1 still needs a 1-bit counter so the ports stay legal.
  function automatic int prescale_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/interval_timer_if.sv
// rtl/interval_timer_if.sv - controller/store <-> interval_timer signal bundle
//
// Purpose: groups the timer request, the parameter-store read path and the
//   timer status into one interface.
// Signals:
//   start_timer   1-cycle restart request
//   req_interval  interval code sampled with start_timer
//   value         seconds returned by the parameter store (registered there)
//   interval      interval select driven to the parameter store
//   busy          high from the start edge until expiry
//   expired       1-cycle expiry pulse
//   remaining     seconds left
//   pause         count hold, present only when TIMER_PAUSE_EN is defined
// Modports: master = controller/store side, slave = interval_timer.
interface interval_timer_if #(
  parameter int TIME_W = 4
) ();

  logic              start_timer;
  logic [1:0]        req_interval;
  logic [TIME_W-1:0] value;
  logic [1:0]        interval;
  logic              busy;
  logic              expired;
  logic [TIME_W-1:0] remaining;
`ifdef TIMER_PAUSE_EN
  logic              pause;

  modport master (
    output start_timer, req_interval, value, pause,
    input  interval, busy, expired, remaining
  );

  modport slave (
    input  start_timer, req_interval, value, pause,
    output interval, busy, expired, remaining
  );
`else
  modport master (
    output start_timer, req_interval, value,
    input  interval, busy, expired, remaining
  );

  modport slave (
    input  start_timer, req_interval, value,
    output interval, busy, expired, remaining
  );
`endif

endinterface

// File: rtl/interval_timer_second_tick.sv
// rtl/interval_timer_second_tick.sv - one-second prescaler with clear and enable
//
// Purpose: counts clk cycles and flags the last cycle of each TICK_DIV period.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous clear to 0 (wins over en)
//   en     in   advance the count this cycle (low = hold)
//   tick   out  combinational, high in the cycle whose edge completes a period
module second_tick
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = prescale_w(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - interval reader and whole-second countdown timer
//
// Purpose: on start_timer, selects the requested interval at the parameter
//   store, waits for the store's registered value, loads it and counts it down
//   one second per TICK_DIV clocks, pulsing expired when it reaches zero.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    interval_timer_if.slave (start_timer, req_interval, value, [pause]
//          in; interval, busy, expired, remaining out)
// Parameters: TICK_DIV clocks per second, TIME_W width of seconds values.
// Build option: TIMER_PAUSE_EN adds bus.pause, holding the count while high.
module interval_timer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int TIME_W   = TIME_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  interval_timer_if.slave  bus
);

  timer_state_t      state;
  timer_state_t      state_d;

  logic [1:0]        interval_q;
  logic [1:0]        interval_d;
  logic              busy_q;
  logic              busy_d;
  logic              expired_q;
  logic              expired_d;
  logic [TIME_W-1:0] remaining_q;
  logic [TIME_W-1:0] remaining_d;

  logic              hold;
  logic              presc_clr;
  logic              presc_en;
  logic              tick;

`ifdef TIMER_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  // Prescaler runs only in COUNT; any start or leaving COUNT zeroes it, so a
  // fresh run always begins its first second from a clean phase at LOAD.
  assign presc_clr = (state != ST_COUNT) || bus.start_timer;
  assign presc_en  = (state == ST_COUNT) && !hold;

  second_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_second_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .en    (presc_en),
    .tick  (tick)
  );

  assign bus.interval  = interval_q;
  assign bus.busy      = busy_q;
  assign bus.expired   = expired_q;
  assign bus.remaining = remaining_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      interval_q  <= INT_BASE;
      busy_q      <= 1'b0;
      expired_q   <= 1'b0;
      remaining_q <= '0;
    end else begin
      state       <= state_d;
      interval_q  <= interval_d;
      busy_q      <= busy_d;
      expired_q   <= expired_d;
      remaining_q <= remaining_d;
    end
  end

  // Next state: a start request restarts from any state, including COUNT on
  // its final tick, so an aborted run never reaches its expiry branch.
  always_comb begin
    state_d = state;
    if (bus.start_timer) begin
      state_d = ST_SEL;
    end else begin
      unique case (state)
        ST_IDLE:  state_d = ST_IDLE;
        ST_SEL:   state_d = ST_WAIT;
        ST_WAIT:  state_d = ST_LOAD;
        ST_LOAD:  state_d = ST_COUNT;
        ST_COUNT: begin
          if (remaining_q == '0) begin
            state_d = ST_IDLE;
          end else if (tick && (remaining_q == TIME_W'(1))) begin
            state_d = ST_IDLE;
          end
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Next register values. interval only changes on a start so the store
  // output stays stable after expiry; expired defaults low for a 1-cycle pulse.
  always_comb begin
    interval_d  = interval_q;
    busy_d      = busy_q;
    expired_d   = 1'b0;
    remaining_d = remaining_q;
    if (bus.start_timer) begin
      interval_d = bus.req_interval;
      busy_d     = 1'b1;
    end else begin
      unique case (state)
        ST_LOAD: begin
          remaining_d = bus.value;
        end
        ST_COUNT: begin
          if (remaining_q == '0) begin
            // Zero-length interval: expire on the first COUNT edge.
            expired_d = 1'b1;
            busy_d    = 1'b0;
          end else if (tick) begin
            if (remaining_q == TIME_W'(1)) begin
              remaining_d = '0;
              expired_d   = 1'b1;
              busy_d      = 1'b0;
            end else begin
              remaining_d = remaining_q - TIME_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// tb/tb_interval_timer.sv - self-checking bench for interval_timer
module tb_interval_timer;
  import traffic_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int TIME_W   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  interval_timer_if #(.TIME_W(TIME_W)) bus ();

  interval_timer #(
    .TICK_DIV (TICK_DIV),
    .TIME_W   (TIME_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Parameter store: one registered read per edge.
  logic [TIME_W-1:0] store_val [4];
  always @(posedge clk) bus.value <= store_val[bus.interval];

  logic pause_in;
`ifdef TIMER_PAUSE_EN
  assign bus.pause = pause_in;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: a run is described by edges since the start edge (d),
  // the value captured for it and the number of unpaused COUNT edges seen.
  // The run loads at d==3 and expires once 4*N counting edges have elapsed
  // (or on the first counting edge when N==0).
  bit         m_active;
  int         m_d;
  int         m_n;
  int         m_eff;
  logic [1:0] e_int;
  bit         e_busy;
  bit         e_exp;
  int         e_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_d = 0; m_n = 0; m_eff = 0;
      e_int = 2'b00; e_busy = 0; e_exp = 0; e_rem = 0;
    end else begin
      e_exp = 0;
      if (bus.start_timer) begin
        m_active = 1;
        m_d      = 0;
        e_int    = bus.req_interval;
        e_busy   = 1;
      end else if (m_active) begin
        m_d++;
        if (m_d == 2) begin
          m_n = int'(store_val[e_int]);
        end else if (m_d == 3) begin
          e_rem = m_n;
          m_eff = 0;
        end else if (m_d > 3) begin
          if (!pause_in) m_eff++;
          if (m_n == 0 || m_eff == TICK_DIV * m_n) begin
            e_exp = 1; e_busy = 0; e_rem = 0; m_active = 0;
          end else begin
            e_rem = m_n - m_eff / TICK_DIV;
          end
        end
      end
    end
  end

  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_interval",  32'(bus.interval),  32'(e_int));
      chk("model_busy",      32'(bus.busy),      32'(e_busy));
      chk("model_expired",   32'(bus.expired),   32'(e_exp));
      chk("model_remaining", 32'(bus.remaining), 32'(e_rem));
    end
  end

  // Pulses start; returns just after the sample following edge S (k=1).
  task automatic pulse_start(input logic [1:0] r);
    @(negedge clk); #1;
    bus.start_timer  = 1'b1;
    bus.req_interval = r;
    @(negedge clk); #1;
    bus.start_timer  = 1'b0;
  endtask

  // Waits for expired; k is the sample index after the start edge, -1 on timeout.
  task automatic wait_expired(input int k0, output int k);
    k = -1;
    for (int i = k0 + 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.expired === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0] req;
    logic [3:0] val;
    int         pause_cyc;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int got;
    bit saw_exp;
    int k;

    bus.start_timer  = 1'b0;
    bus.req_interval = 2'b00;
    pause_in         = 1'b0;
    for (int i = 0; i < 4; i++) store_val[i] = '0;

    // Expiry sample index = 4 + N*TICK_DIV + paused cycles; zero value -> 5.
    vecs.push_back('{INT_BASE, 4'd6, 0, 28});
    vecs.push_back('{INT_YEL,  4'd0, 0, 5});
    vecs.push_back('{INT_EXT,  4'd3, 0, 16});
    vecs.push_back('{INT_RSVD, 4'd1, 0, 8});
`ifdef TIMER_PAUSE_EN
    vecs.push_back('{INT_EXT,  4'd2, 5, 17});
`endif

    // Reset
    #1 rst_n = 1'b0;
    chk_on = 1;
    repeat (3) @(negedge clk);
    chk("rst_interval",  32'(bus.interval),  32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_expired",   32'(bus.expired),   32'd0);
    chk("rst_remaining", 32'(bus.remaining), 32'd0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven runs
    foreach (vecs[i]) begin
      @(negedge clk); #1;
      store_val[vecs[i].req] = vecs[i].val;
      pulse_start(vecs[i].req);
      chk("tbl_interval_after_s", 32'(bus.interval), 32'(vecs[i].req));
      got = -1;
      for (int kk = 2; kk <= 200; kk++) begin
        @(negedge clk);
        if (kk == 4) chk("tbl_load_remaining", 32'(bus.remaining), 32'(vecs[i].val));
        if (bus.expired === 1'b1) begin
          got = kk;
          break;
        end
        #1 pause_in = (kk >= 6 && kk < 6 + vecs[i].pause_cyc);
      end
      pause_in = 1'b0;
      chk("tbl_expire_latency", 32'(got), 32'(vecs[i].lat));
      chk("tbl_busy_at_expiry", 32'(bus.busy), 32'd0);
      chk("tbl_rem_at_expiry",  32'(bus.remaining), 32'd0);
      @(negedge clk);
      chk("tbl_expired_width", 32'(bus.expired), 32'd0);
      chk("tbl_interval_held", 32'(bus.interval), 32'(vecs[i].req));
    end

    // Abort: restart a 3-second run at remaining==2 with a 2-second run
    @(negedge clk); #1;
    store_val[INT_EXT] = 4'd3;
    store_val[INT_YEL] = 4'd2;
    pulse_start(INT_EXT);
    saw_exp = 0;
    got = -1;
    for (int kk = 2; kk <= 60; kk++) begin
      @(negedge clk);
      if (bus.expired === 1'b1) saw_exp = 1;
      if (bus.remaining == 4'd2) begin
        got = kk;
        break;
      end
    end
    chk("abort_reached_rem2", 32'(got), 32'd8);
    #1;
    bus.start_timer  = 1'b1;
    bus.req_interval = INT_YEL;
    @(negedge clk); #1;
    bus.start_timer  = 1'b0;
    chk("abort_interval", 32'(bus.interval), 32'(INT_YEL));
    wait_expired(1, got);
    chk("abort_no_first_expiry", 32'(saw_exp), 32'd0);
    chk("abort_new_latency", 32'(got), 32'd12);

    // Store reprogram mid-count, then reset mid-count
    @(negedge clk); #1;
    store_val[INT_BASE] = 4'd4;
    pulse_start(INT_BASE);
    repeat (6) @(negedge clk);
    #1 store_val[INT_BASE] = 4'd15;
    repeat (5) @(negedge clk);
    chk("reprog_remaining", 32'(bus.remaining), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_interval",  32'(bus.interval),  32'd0);
    chk("midrst_busy",      32'(bus.busy),      32'd0);
    chk("midrst_expired",   32'(bus.expired),   32'd0);
    chk("midrst_remaining", 32'(bus.remaining), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    pulse_start(INT_BASE);
    repeat (3) @(negedge clk);
    chk("reprog_new_value", 32'(bus.remaining), 32'd15);
    wait_expired(4, got);
    chk("reprog_new_latency", 32'(got), 32'd64);

    // Randomised runs, with random aborts, store changes and (if built) pauses
    for (int r = 0; r < 40; r++) begin
      logic [1:0] req;
      int len;
      req = 2'($urandom_range(0, 3));
      @(negedge clk); #1;
      store_val[req] = 4'($urandom_range(0, 4));
      pulse_start(req);
      len = $urandom_range(1, 30);
      for (int j = 0; j < len; j++) begin
        @(negedge clk); #1;
`ifdef TIMER_PAUSE_EN
        pause_in = ($urandom_range(0, 3) == 0);
`endif
        if ($urandom_range(0, 9) == 0) store_val[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
      end
    end
    pause_in = 1'b0;
    k = 0;
    while (bus.busy === 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("random_drain_idle", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
